// File: rtl/fp16_align_stage.sv
// FP16 adder front end: unpack, swap by magnitude, align the smaller significand
// with sticky, invert for effective subtract. Optional macro: FP16_DENORM_EN.
module fp16_align_stage #(
    parameter int EXP_W  = 5,
    parameter int FRAC_W = 10,
    parameter int MAN_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        in_a,
    input  logic [15:0]        in_b,
    input  logic               in_sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MAN_W-1:0]   out_ma,
    output logic [MAN_W-1:0]   out_mb,
    output logic               out_cin,
    output logic [EXP_W-1:0]   out_exp,
    output logic               out_sign,
    output logic               out_eff_sub,
    output logic               out_special,
    output logic [15:0]        out_special_val
);

    localparam int SIG_W = FRAC_W + 1;
    localparam int PAD_W = MAN_W - SIG_W - 3;
    localparam logic [EXP_W-1:0] EXP_MAX   = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] FAR_SHIFT = EXP_W'(FRAC_W + 4);

    logic adv1, adv2;

    logic [EXP_W-1:0]  raw_exp_a, raw_exp_b, exp_a, exp_b, exp_x, exp_y;
    logic [FRAC_W-1:0] frac_a, frac_b;
    logic [SIG_W-1:0]  sig_a, sig_b, sig_x, sig_y;
    logic              sign_a, sign_b, eff_sub, swap, mag_eq, res_sign;
    logic              nan_a, nan_b, inf_a, inf_b, special;
    logic [15:0]       special_val;

    logic              s1_valid;
    logic [SIG_W-1:0]  s1_sig_x, s1_sig_y;
    logic [EXP_W-1:0]  s1_exp, s1_diff;
    logic              s1_eff_sub, s1_sign, s1_special;
    logic [15:0]       s1_special_val;

    logic [MAN_W-1:0]  aligned_y, lost_mask, y_aligned;

    assign adv2     = ~out_valid | out_ready;
    assign adv1     = ~s1_valid | adv2;
    assign in_ready = adv1;

    assign raw_exp_a = in_a[FRAC_W +: EXP_W];
    assign raw_exp_b = in_b[FRAC_W +: EXP_W];
    assign frac_a    = in_a[FRAC_W-1:0];
    assign frac_b    = in_b[FRAC_W-1:0];
    assign sign_a    = in_a[15];
    assign sign_b    = in_b[15] ^ in_sub;
    assign eff_sub   = sign_a ^ sign_b;

    assign nan_a = (raw_exp_a == EXP_MAX) && (frac_a != '0);
    assign nan_b = (raw_exp_b == EXP_MAX) && (frac_b != '0);
    assign inf_a = (raw_exp_a == EXP_MAX) && (frac_a == '0);
    assign inf_b = (raw_exp_b == EXP_MAX) && (frac_b == '0);

    always_comb begin
`ifdef FP16_DENORM_EN
        exp_a = (raw_exp_a == '0) ? EXP_W'(1) : raw_exp_a;
        exp_b = (raw_exp_b == '0) ? EXP_W'(1) : raw_exp_b;
        sig_a = {raw_exp_a != '0, frac_a};
        sig_b = {raw_exp_b != '0, frac_b};
`else
        exp_a = raw_exp_a;
        exp_b = raw_exp_b;
        sig_a = (raw_exp_a == '0) ? '0 : {1'b1, frac_a};
        sig_b = (raw_exp_b == '0) ? '0 : {1'b1, frac_b};
`endif
    end

    // Comparing {exp, sig} orders magnitudes the same way {exp, frac} does, and also
    // treats flushed denormals as true zeros.
    always_comb begin
        swap     = {exp_b, sig_b} > {exp_a, sig_a};
        mag_eq   = {exp_b, sig_b} == {exp_a, sig_a};
        exp_x    = swap ? exp_b : exp_a;
        exp_y    = swap ? exp_a : exp_b;
        sig_x    = swap ? sig_b : sig_a;
        sig_y    = swap ? sig_a : sig_b;
        res_sign = (eff_sub && mag_eq) ? 1'b0 : (swap ? sign_b : sign_a);

        special     = 1'b0;
        special_val = '0;
        if (nan_a || nan_b || (inf_a && inf_b && eff_sub)) begin
            special     = 1'b1;
            special_val = 16'h7E00;
        end else if (inf_a) begin
            special     = 1'b1;
            special_val = {sign_a, 5'h1F, 10'h000};
        end else if (inf_b) begin
            special     = 1'b1;
            special_val = {sign_b, 5'h1F, 10'h000};
        end
    end

    always_comb begin
        aligned_y = {{PAD_W{1'b0}}, s1_sig_y, 3'b000};
        lost_mask = ~({MAN_W{1'b1}} << s1_diff);
        if (s1_diff >= FAR_SHIFT)
            y_aligned = {{(MAN_W-1){1'b0}}, |s1_sig_y};
        else
            y_aligned = (aligned_y >> s1_diff)
                      | {{(MAN_W-1){1'b0}}, |(aligned_y & lost_mask)};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid        <= 1'b0;
            s1_sig_x        <= '0;
            s1_sig_y        <= '0;
            s1_exp          <= '0;
            s1_diff         <= '0;
            s1_eff_sub      <= 1'b0;
            s1_sign         <= 1'b0;
            s1_special      <= 1'b0;
            s1_special_val  <= '0;
            out_valid       <= 1'b0;
            out_ma          <= '0;
            out_mb          <= '0;
            out_cin         <= 1'b0;
            out_exp         <= '0;
            out_sign        <= 1'b0;
            out_eff_sub     <= 1'b0;
            out_special     <= 1'b0;
            out_special_val <= '0;
        end else begin
            if (adv1) begin
                s1_valid       <= in_valid;
                s1_sig_x       <= sig_x;
                s1_sig_y       <= sig_y;
                s1_exp         <= exp_x;
                s1_diff        <= exp_x - exp_y;
                s1_eff_sub     <= eff_sub;
                s1_sign        <= res_sign;
                s1_special     <= special;
                s1_special_val <= special_val;
            end
            if (adv2) begin
                out_valid       <= s1_valid;
                out_ma          <= {{PAD_W{1'b0}}, s1_sig_x, 3'b000};
                out_mb          <= s1_eff_sub ? ~y_aligned : y_aligned;
                out_cin         <= s1_eff_sub;
                out_exp         <= s1_exp;
                out_sign        <= s1_sign;
                out_eff_sub     <= s1_eff_sub;
                out_special     <= s1_special;
                out_special_val <= s1_special_val;
            end
        end
    end

endmodule

// File: tb/tb_fp16_align_stage.sv
// Scoreboard bench for fp16_align_stage; follows FP16_DENORM_EN like the design.
module tb_fp16_align_stage;

    typedef struct packed {
        logic [15:0] ma;
        logic [15:0] mb;
        logic        cin;
        logic [4:0]  ex;
        logic        sign;
        logic        eff_sub;
        logic        special;
        logic [15:0] sval;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_ma, out_mb;
    logic        out_cin;
    logic [4:0]  out_exp;
    logic        out_sign, out_eff_sub, out_special;
    logic [15:0] out_special_val;

    int   n_tests = 0;
    int   n_fail = 0;
    int   n_pop = 0;
    exp_t sb[$];

    logic        held_ok = 1'b0;
    logic [15:0] held_ma, held_mb;

    fp16_align_stage #(.EXP_W(5), .FRAC_W(10), .MAN_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ma(out_ma), .out_mb(out_mb), .out_cin(out_cin), .out_exp(out_exp),
        .out_sign(out_sign), .out_eff_sub(out_eff_sub),
        .out_special(out_special), .out_special_val(out_special_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic exp_t mk(logic [15:0] ma, logic [15:0] mb, logic cin,
                                logic [4:0] ex, logic sign);
        exp_t r = '0;
        r.ma = ma; r.mb = mb; r.cin = cin; r.ex = ex; r.sign = sign; r.eff_sub = cin;
        return r;
    endfunction

    function automatic exp_t mk_sp(logic [15:0] v);
        exp_t r = '0;
        r.special = 1'b1; r.sval = v;
        return r;
    endfunction

    function automatic exp_t model(logic [15:0] a, logic [15:0] b, logic sub);
        exp_t r = '0;
        logic sa, sbb, eff, nan_a, nan_b, inf_a, inf_b, sx;
        int unsigned ea, eb, fa, fb, xa, xb, ga, gb, ex, ey, gx, gy, mag_a, mag_b;
        int unsigned diff, yfull, yv;
        sa = a[15]; sbb = b[15] ^ sub; eff = sa ^ sbb;
        ea = a[14:10]; fa = a[9:0]; eb = b[14:10]; fb = b[9:0];
        nan_a = (ea == 31) && (fa != 0); inf_a = (ea == 31) && (fa == 0);
        nan_b = (eb == 31) && (fb != 0); inf_b = (eb == 31) && (fb == 0);
        r.eff_sub = eff; r.cin = eff;
        if (nan_a || nan_b || (inf_a && inf_b && eff)) return mk_sp(16'h7E00);
        if (inf_a) return mk_sp({sa, 5'h1F, 10'h0});
        if (inf_b) return mk_sp({sbb, 5'h1F, 10'h0});
`ifdef FP16_DENORM_EN
        xa = (ea == 0) ? 1 : ea; ga = (ea == 0) ? fa : fa + 1024;
        xb = (eb == 0) ? 1 : eb; gb = (eb == 0) ? fb : fb + 1024;
`else
        xa = ea; ga = (ea == 0) ? 0 : fa + 1024;
        xb = eb; gb = (eb == 0) ? 0 : fb + 1024;
`endif
        mag_a = xa * 4096 + ga;
        mag_b = xb * 4096 + gb;
        if (mag_b > mag_a) begin ex = xb; gx = gb; ey = xa; gy = ga; sx = sbb; end
        else               begin ex = xa; gx = ga; ey = xb; gy = gb; sx = sa;  end
        diff = ex - ey;
        if (diff >= 14) yv = (gy != 0) ? 1 : 0;
        else begin
            yfull = gy * 8;
            yv = yfull >> diff;
            if ((yfull % (1 << diff)) != 0) yv = yv | 1;
        end
        r.ma   = 16'(gx * 8);
        r.mb   = eff ? ~16'(yv) : 16'(yv);
        r.ex   = 5'(ex);
        r.sign = (eff && mag_a == mag_b) ? 1'b0 : sx;
        return r;
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] v = 16'($urandom);
        case ($urandom_range(0, 7))
            0: ;
            1: v[14:10] = 5'h00;
            2: v[14:0] = 15'h7C00;
            3: begin v[14:10] = 5'h1F; v[0] = 1'b1; end
            4: v[14:0] = {5'h0F, 10'h000};
            default: v[14:10] = 5'(10 + $urandom_range(0, 10));
        endcase
        return v;
    endfunction

    // One cycle: drive at negedge, let in_ready settle, record acceptance, advance.
    task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic ordy, input exp_t e, output logic acc);
        @(negedge clk);
        in_valid = v; in_a = a; in_b = b; in_sub = s; out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        if (acc) sb.push_back(e);
        @(posedge clk);
    endtask

    always @(negedge clk) begin
        #2;
        if (!reset) begin
            if (out_valid && !out_ready) begin
                if (held_ok) begin
                    check("hold_ma", 32'(out_ma), 32'(held_ma));
                    check("hold_mb", 32'(out_mb), 32'(held_mb));
                end
                held_ma = out_ma; held_mb = out_mb; held_ok = 1'b1;
            end else begin
                held_ok = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'(out_valid), 32'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    n_pop++;
                    check("special", 32'(out_special), 32'(e.special));
                    check("special_val", 32'(out_special_val), 32'(e.sval));
                    if (!e.special) begin
                        check("ma", 32'(out_ma), 32'(e.ma));
                        check("mb", 32'(out_mb), 32'(e.mb));
                        check("cin", 32'(out_cin), 32'(e.cin));
                        check("exp", 32'(out_exp), 32'(e.ex));
                        check("sign", 32'(out_sign), 32'(e.sign));
                        check("eff_sub", 32'(out_eff_sub), 32'(e.eff_sub));
                    end
                end
            end
        end
    end

    initial begin
        logic acc;
        int   n0, tries;
        logic [15:0] ra, rb;
        logic rs, rv, ro;

        #1;
        check("reset_out_valid", 32'(out_valid), 32'(0));
        check("reset_in_ready", 32'(in_ready), 32'(1));
        check("reset_ma", 32'(out_ma), 32'(0));
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        step(1, 16'h3C00, 16'h3C00, 0, 1, mk(16'h2000, 16'h2000, 0, 5'h0F, 0), acc);
        step(1, 16'h3C00, 16'hB800, 0, 1, mk(16'h2000, 16'hEFFF, 1, 5'h0F, 0), acc);
`ifdef FP16_DENORM_EN
        step(1, 16'h3C00, 16'h0001, 0, 1, mk(16'h2000, 16'h0001, 0, 5'h0F, 0), acc);
`else
        step(1, 16'h3C00, 16'h0001, 0, 1, mk(16'h2000, 16'h0000, 0, 5'h0F, 0), acc);
`endif
        step(1, 16'h4000, 16'h4000, 1, 1, mk(16'h2000, 16'hDFFF, 1, 5'h10, 0), acc);
        step(1, 16'h3800, 16'h3C00, 1, 1, mk(16'h2000, 16'hEFFF, 1, 5'h0F, 1), acc);
        step(1, 16'h7C00, 16'hFC00, 0, 1, mk_sp(16'h7E00), acc);
        step(1, 16'h7C00, 16'h3C00, 0, 1, mk_sp(16'h7C00), acc);
        step(1, 16'h3C00, 16'h7C00, 1, 1, mk_sp(16'hFC00), acc);
        step(1, 16'h7C01, 16'h3C00, 0, 1, mk_sp(16'h7E00), acc);
        for (int i = 0; i < 4; i++) step(0, '0, '0, 0, 1, '0, acc);
        check("directed_count", 32'(n_pop), 32'(9));

        n0 = n_pop;
        step(1, 16'h4200, 16'h3C00, 0, 0, model(16'h4200, 16'h3C00, 0), acc);
        check("bp_acc0", 32'(acc), 32'(1));
        step(1, 16'h4400, 16'h3A00, 1, 0, model(16'h4400, 16'h3A00, 1), acc);
        check("bp_acc1", 32'(acc), 32'(1));
        step(1, 16'h4600, 16'hC000, 0, 0, model(16'h4600, 16'hC000, 0), acc);
        check("bp_in_ready", 32'(acc), 32'(0));
        step(1, 16'h4600, 16'hC000, 0, 0, model(16'h4600, 16'hC000, 0), acc);
        check("bp_still_held", 32'(acc), 32'(0));
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 5) begin
            step(1, 16'h4600, 16'hC000, 0, 1, model(16'h4600, 16'hC000, 0), acc);
            tries++;
        end
        check("bp_third_accepted", 32'(acc), 32'(1));
        for (int i = 0; i < 4; i++) step(0, '0, '0, 0, 1, '0, acc);
        check("bp_count", 32'(n_pop - n0), 32'(3));

        for (int i = 0; i < 400; i++) begin
            ra = rand_op(); rb = rand_op(); rs = 1'($urandom);
            rv = ($urandom_range(0, 9) < 7); ro = ($urandom_range(0, 9) < 7);
            step(rv, ra, rb, rs, ro, model(ra, rb, rs), acc);
        end
        for (int i = 0; i < 6; i++) step(0, '0, '0, 0, 1, '0, acc);
        check("drain_empty", 32'(sb.size()), 32'(0));

        step(1, 16'h3C00, 16'h3C00, 0, 0, model(16'h3C00, 16'h3C00, 0), acc);
        step(1, 16'h4000, 16'h3C00, 0, 0, model(16'h4000, 16'h3C00, 0), acc);
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_reset_out_valid", 32'(out_valid), 32'(1));
        #3 reset = 1'b1;
        #1;
        check("async_reset_out_valid", 32'(out_valid), 32'(0));
        check("async_reset_in_ready", 32'(in_ready), 32'(1));
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(0, '0, '0, 0, 1, '0, acc);
            check("post_reset_no_output", 32'(out_valid), 32'(0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
